run_sequencer: RTL and testbench
================================

RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 SHALL have parameter RUN_WIDTH, default 16: width of the RUN cycle count.
REQ-002 SHALL take NET_NUM_INP and NET_CHARGE_WIDTH from network_config; neither is a port parameter.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 cmd_valid  in  1  command beat offered.
REQ-006 cmd_ready  out  1  command beat accepted when cmd_valid && cmd_ready.
REQ-007 cmd  in  CMD_WIDTH  {opcode[1:0], payload}, MSB-first.
REQ-008 net_ready  in  1  downstream network accepts a beat.
REQ-009 net_valid  out  1  network beat offered.
REQ-010 net_clr  out  1  beat is a network clear; qualified by net_valid.
REQ-011 net_inp  out  signed NET_CHARGE_WIDTH x [0:NET_NUM_INP-1]  per-input charge for the beat.
REQ-012 busy  out  1  high whenever state != IDLE.

Function
REQ-013 Opcodes: NOP=0, SPK=1, RUN=2, CLR=3.
REQ-014 SPK payload: {idx[IDX_WIDTH-1:0], charge[NET_CHARGE_WIDTH-1:0]} in the low payload bits. IDX_WIDTH=max(1,$clog2(NET_NUM_INP)).
REQ-015 RUN payload: count[RUN_WIDTH-1:0] in the low payload bits.
REQ-016 The FSM has three states: IDLE, RUN, CLR.
REQ-017 cmd_ready SHALL be 1 only in IDLE.
REQ-018 NOP is accepted with no effect.
REQ-019 SPK is accepted in one cycle.
  - It adds the charge to buf[idx], saturating to the signed NET_CHARGE_WIDTH range.
  - If idx >= NET_NUM_INP, it is accepted and ignored.
REQ-020 RUN with count=0 is accepted, emits no beat and stays in IDLE.
REQ-021 RUN with count=n>0 loads remaining=n and enters RUN on the next cycle.
REQ-022 In RUN, net_valid=1 and net_clr=0.
  - The first beat carries buf; subsequent beats carry all-zero charges.
REQ-023 Each RUN handshake (net_valid && net_ready) decrements remaining.
  - The first handshake also clears buf.
  - The handshake with remaining=1 returns the FSM to IDLE.
REQ-024 CLR is accepted and enters CLR.
  - In CLR, net_valid=1, net_clr=1 and net_inp is all zero.
  - On handshake, buf is zeroed and the FSM returns to IDLE.
REQ-025 net_valid, net_clr and net_inp SHALL hold stable while net_valid && !net_ready (no beat dropped or altered).
REQ-026 Outputs SHALL be registered; the first beat appears 1 cycle after RUN/CLR acceptance.
REQ-027 With net_ready held high, RUN n occupies exactly n consecutive beat cycles; the next command is accepted the following cycle.
REQ-028 Maximum count 2^RUN_WIDTH-1 SHALL run to completion without wrap.

Reset
REQ-029 On rst, in the cycle after: state=IDLE, buf all zero, remaining=0, net_valid=0, net_clr=0, net_inp all zero, busy=0, cmd_ready=1.
REQ-030 rst mid-RUN or mid-CLR SHALL abort the sequence: no further beats, and pending SPK charges are discarded.
REQ-031 rst SHALL take priority over any simultaneous handshake.

Structure
REQ-032 Package seq_config SHALL hold: opcode_t enum, OPC_WIDTH=2, IDX_WIDTH, CMD_WIDTH=OPC_WIDTH+max(RUN_WIDTH, IDX_WIDTH+NET_CHARGE_WIDTH), and state_t.
REQ-033 Saturating signed add SHALL be a sub-module sat_add, parameterised by width.
REQ-034 The remainder SHALL be a single module with no other hierarchy.

Verification
REQ-035 With NET_NUM_INP=4 and width 8, the bench SHALL cover the following scenarios:
  - SPK(1,+5), SPK(1,+3), RUN 3, net_ready=1 -> beats {0,8,0,0}, {0,0,0,0}, {0,0,0,0}, then idle.
  - SPK(2,+100), SPK(2,+100) -> buf[2]=127; SPK(0,-100) x2 -> buf[0]=-128.
  - RUN 2 with net_ready low 5 cycles on beat 1 -> beat 1 held unchanged 5 cycles, still exactly 2 beats.
  - SPK(3,+7), CLR -> one beat net_clr=1 with zero charges; the following RUN 1 carries all zeros.
  - RUN 0 and SPK(idx=5) -> no beat, cmd_ready stays 1, buf unchanged.
  - rst asserted on beat 2 of RUN 10 -> net_valid=0 the next cycle, busy=0, buf zero.

Source files
------------

// File: rtl/run_sequencer_pkg.sv
// Configuration packages for the run sequencer.
//   network_config : shape of the downstream network (input count, charge width)
//   seq_config     : command encoding, opcodes and sequencer state encoding
package network_config;
  localparam int NET_NUM_INP      = 4;
  localparam int NET_CHARGE_WIDTH = 8;
endpackage

package seq_config;
  import network_config::*;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_SPK = 2'd1,
    OP_RUN = 2'd2,
    OP_CLR = 2'd3
  } opcode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_CLR  = 2'd2
  } state_t;

  localparam int OPC_WIDTH     = 2;
  localparam int IDX_WIDTH     = ($clog2(NET_NUM_INP) > 1) ? $clog2(NET_NUM_INP) : 1;
  localparam int RUN_WIDTH_DEF = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Payload must hold either a RUN count or an {idx, charge} pair.
  function automatic int payload_width(input int run_w);
    return max_int(run_w, IDX_WIDTH + NET_CHARGE_WIDTH);
  endfunction

  localparam int CMD_WIDTH = OPC_WIDTH + payload_width(RUN_WIDTH_DEF);
endpackage

// File: rtl/run_sequencer_sat_add.sv
// sat_add: signed add clamped to the signed W-bit range.
//   a_i, b_i : signed operands
//   y_o      : a_i + b_i, saturated to [-2^(W-1), 2^(W-1)-1]
module sat_add #(
  parameter int W = 8
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] y_o
);
  logic [W:0] sum;

  assign sum = {a_i[W-1], a_i} + {b_i[W-1], b_i};

  // Overflow iff the extra sign bit disagrees with the result sign.
  always_comb begin
    y_o = sum[W-1:0];
    if (sum[W] != sum[W-1])
      y_o = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end
endmodule

// File: rtl/run_sequencer.sv
// run_sequencer: accumulates spike charges per network input and replays them
// to the network as RUN beat sequences or CLR beats.
//   clk, rst             : clock, synchronous active-high reset
//   cmd_valid/cmd_ready  : command handshake, cmd = {opcode, payload}
//   net_valid/net_ready  : network beat handshake
//   net_clr              : beat is a network clear
//   net_inp              : per-input signed charge carried by the beat
//   busy                 : sequencer is not idle
module run_sequencer
  import network_config::*;
  import seq_config::*;
#(
  parameter  int RUN_WIDTH = 16,
  localparam int PAY_W     = payload_width(RUN_WIDTH),
  localparam int CMD_W     = OPC_WIDTH + PAY_W
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [CMD_W-1:0]                   cmd,
  input  logic                               net_ready,
  output logic                               net_valid,
  output logic                               net_clr,
  output logic signed [NET_CHARGE_WIDTH-1:0] net_inp [0:NET_NUM_INP-1],
  output logic                               busy
);
  localparam int CW     = NET_CHARGE_WIDTH;
  localparam int XIDX_W = PAY_W - CW;
  localparam logic [RUN_WIDTH-1:0] ONE = RUN_WIDTH'(1);

  typedef logic signed [CW-1:0] chg_t;

  state_t               state_q, state_d;
  logic [RUN_WIDTH-1:0] remaining_q, remaining_d;
  chg_t                 buf_q [NET_NUM_INP];
  chg_t                 buf_d [NET_NUM_INP];
  logic                 net_valid_q, net_valid_d;
  logic                 net_clr_q, net_clr_d;
  chg_t                 net_inp_q [NET_NUM_INP];
  chg_t                 net_inp_d [NET_NUM_INP];

  // Command decode
  opcode_t              opc;
  logic [PAY_W-1:0]     payload;
  logic [XIDX_W-1:0]    spk_idx;
  logic [IDX_WIDTH-1:0] spk_sel;
  chg_t                 spk_chg;
  chg_t                 spk_sum;
  logic                 spk_hit;
  logic [RUN_WIDTH-1:0] run_cnt;
  logic                 accept, hs;

  assign opc     = opcode_t'(cmd[CMD_W-1 -: OPC_WIDTH]);
  assign payload = cmd[PAY_W-1:0];
  // The whole field above the charge is the index, so stray high bits
  // read as an out-of-range input and the spike is dropped rather than aliased.
  assign spk_idx = payload[PAY_W-1:CW];
  assign spk_sel = spk_idx[IDX_WIDTH-1:0];
  assign spk_chg = payload[CW-1:0];
  assign spk_hit = 32'(spk_idx) < 32'(NET_NUM_INP);
  assign run_cnt = payload[RUN_WIDTH-1:0];

  assign accept  = cmd_valid && (state_q == S_IDLE);
  assign hs      = net_valid_q && net_ready;

  sat_add #(.W(CW)) u_sat_add (
    .a_i (buf_q[spk_sel]),
    .b_i (spk_chg),
    .y_o (spk_sum)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) begin
        if (opc == OP_RUN && run_cnt != '0) state_d = S_RUN;
        else if (opc == OP_CLR)             state_d = S_CLR;
      end
      S_RUN:   if (hs && remaining_q == ONE) state_d = S_IDLE;
      S_CLR:   if (hs)                       state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next outputs / datapath. Beat outputs are computed one cycle ahead and
  // registered, so they only move on acceptance or handshake edges and stay
  // frozen while the network stalls.
  always_comb begin
    remaining_d = remaining_q;
    net_valid_d = net_valid_q;
    net_clr_d   = net_clr_q;
    for (int i = 0; i < NET_NUM_INP; i++) begin
      buf_d[i]     = buf_q[i];
      net_inp_d[i] = net_inp_q[i];
    end
    case (state_q)
      S_IDLE: if (accept) begin
        case (opc)
          OP_SPK: if (spk_hit) buf_d[spk_sel] = spk_sum;
          OP_RUN: if (run_cnt != '0) begin
            remaining_d = run_cnt;
            net_valid_d = 1'b1;
            net_clr_d   = 1'b0;
            for (int i = 0; i < NET_NUM_INP; i++) net_inp_d[i] = buf_q[i];
          end
          OP_CLR: begin
            net_valid_d = 1'b1;
            net_clr_d   = 1'b1;
            for (int i = 0; i < NET_NUM_INP; i++) net_inp_d[i] = '0;
          end
          default: ;
        endcase
      end
      S_RUN: if (hs) begin
        remaining_d = remaining_q - ONE;
        // Only the first beat carries charge; clearing buf on every beat is
        // equivalent since it is already zero after the first.
        for (int i = 0; i < NET_NUM_INP; i++) begin
          buf_d[i]     = '0;
          net_inp_d[i] = '0;
        end
        if (remaining_q == ONE) net_valid_d = 1'b0;
      end
      S_CLR: if (hs) begin
        net_valid_d = 1'b0;
        net_clr_d   = 1'b0;
        for (int i = 0; i < NET_NUM_INP; i++) buf_d[i] = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_q <= '0;
      net_valid_q <= 1'b0;
      net_clr_q   <= 1'b0;
      for (int i = 0; i < NET_NUM_INP; i++) begin
        buf_q[i]     <= '0;
        net_inp_q[i] <= '0;
      end
    end else begin
      remaining_q <= remaining_d;
      net_valid_q <= net_valid_d;
      net_clr_q   <= net_clr_d;
      for (int i = 0; i < NET_NUM_INP; i++) begin
        buf_q[i]     <= buf_d[i];
        net_inp_q[i] <= net_inp_d[i];
      end
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign net_valid = net_valid_q;
  assign net_clr   = net_clr_q;
  assign net_inp   = net_inp_q;
endmodule

// File: tb/tb_run_sequencer.sv
module tb_run_sequencer;
  import network_config::*;
  import seq_config::*;

  logic clk = 1'b0;
  logic rst, cmd_valid, cmd_ready, net_ready, net_valid, net_clr, busy;
  logic [CMD_WIDTH-1:0] cmd;
  logic signed [NET_CHARGE_WIDTH-1:0] net_inp [0:NET_NUM_INP-1];

  int tests = 0;
  int fails = 0;
  logic [32:0] beats[$];
  logic [32:0] held[$];

  always #5 clk = ~clk;

  run_sequencer #(.RUN_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .net_ready(net_ready), .net_valid(net_valid), .net_clr(net_clr),
    .net_inp(net_inp), .busy(busy)
  );

  // Beat as {clr, inp0, inp1, inp2, inp3}
  function automatic logic [32:0] cur_beat();
    return {net_clr, net_inp[0], net_inp[1], net_inp[2], net_inp[3]};
  endfunction

  function automatic logic [32:0] mk(input logic c, input int a0, input int a1,
                                     input int a2, input int a3);
    return {c, 8'(a0), 8'(a1), 8'(a2), 8'(a3)};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input opcode_t op, input logic [15:0] pl);
    cmd_valid = 1'b1;
    cmd = {op, pl};
    tick();
    cmd_valid = 1'b0;
    cmd = '0;
  endtask

  task automatic spk(input int idx, input int ch);
    send(OP_SPK, {8'(idx), 8'(ch)});
  endtask

  // Drains beats until idle; stalls the first beat for 'stall' cycles.
  task automatic collect(input int stall, input int budget, output bit to, output int cyc);
    int s;
    s = stall;
    to = 1'b0;
    cyc = 0;
    beats.delete();
    held.delete();
    forever begin
      if (cyc >= budget) begin to = 1'b1; break; end
      if (net_valid) begin
        if (s > 0) begin net_ready = 1'b0; held.push_back(cur_beat()); s--; end
        else begin net_ready = 1'b1; beats.push_back(cur_beat()); end
      end else if (!busy) break;
      else net_ready = 1'b1;
      tick();
      cyc++;
    end
    net_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests++; if (net_valid !== 1'b0) begin fails++; $display("FAIL reset_net_valid: got %b expected 0", net_valid); end
    tests++; if (net_clr !== 1'b0) begin fails++; $display("FAIL reset_net_clr: got %b expected 0", net_clr); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    tests++; if (cur_beat() !== 33'd0) begin fails++; $display("FAIL reset_net_inp: got %h expected 0", cur_beat()); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_spk_run();
    bit to; int cyc;
    spk(1, 5);
    spk(1, 3);
    send(OP_RUN, 16'd3);
    collect(0, 20, to, cyc);
    tests++; if (to || beats.size() != 3) begin fails++; $display("FAIL run3_count: got %0d beats (timeout %0b) expected 3", beats.size(), to); end
    else begin
      tests++; if (beats[0] !== mk(0, 0, 8, 0, 0)) begin fails++; $display("FAIL run3_beat0: got %h expected %h", beats[0], mk(0, 0, 8, 0, 0)); end
      tests++; if (beats[1] !== 33'd0) begin fails++; $display("FAIL run3_beat1: got %h expected 0", beats[1]); end
      tests++; if (beats[2] !== 33'd0) begin fails++; $display("FAIL run3_beat2: got %h expected 0", beats[2]); end
    end
    tests++; if (cyc != 3) begin fails++; $display("FAIL run3_cycles: got %0d expected 3", cyc); end
    tests++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL run3_idle: got ready=%b busy=%b expected 1/0", cmd_ready, busy); end
  endtask

  task automatic test_saturation();
    bit to; int cyc;
    spk(2, 100);
    spk(2, 100);
    spk(0, -100);
    spk(0, -100);
    send(OP_RUN, 16'd1);
    collect(0, 20, to, cyc);
    tests++; if (to || beats.size() != 1) begin fails++; $display("FAIL sat_count: got %0d beats expected 1", beats.size()); end
    else begin
      tests++; if (beats[0] !== mk(0, -128, 0, 127, 0)) begin fails++; $display("FAIL sat_beat: got %h expected %h", beats[0], mk(0, -128, 0, 127, 0)); end
    end
  endtask

  task automatic test_backpressure();
    bit to; int cyc; int bad;
    spk(0, 9);
    spk(3, -2);
    send(OP_RUN, 16'd2);
    collect(5, 30, to, cyc);
    tests++; if (to || beats.size() != 2) begin fails++; $display("FAIL bp_count: got %0d beats expected 2", beats.size()); end
    else begin
      tests++; if (beats[0] !== mk(0, 9, 0, 0, -2)) begin fails++; $display("FAIL bp_beat0: got %h expected %h", beats[0], mk(0, 9, 0, 0, -2)); end
      tests++; if (beats[1] !== 33'd0) begin fails++; $display("FAIL bp_beat1: got %h expected 0", beats[1]); end
    end
    bad = 0;
    foreach (held[i]) if (held[i] !== mk(0, 9, 0, 0, -2)) bad++;
    tests++; if (held.size() != 5 || bad != 0) begin fails++; $display("FAIL bp_hold: got %0d held, %0d altered expected 5 held, 0 altered", held.size(), bad); end
    tests++; if (cyc != 7) begin fails++; $display("FAIL bp_cycles: got %0d expected 7", cyc); end
  endtask

  task automatic test_clr();
    bit to; int cyc;
    spk(3, 7);
    send(OP_CLR, 16'd0);
    collect(0, 20, to, cyc);
    tests++; if (to || beats.size() != 1) begin fails++; $display("FAIL clr_count: got %0d beats expected 1", beats.size()); end
    else begin
      tests++; if (beats[0] !== mk(1, 0, 0, 0, 0)) begin fails++; $display("FAIL clr_beat: got %h expected %h", beats[0], mk(1, 0, 0, 0, 0)); end
    end
    send(OP_RUN, 16'd1);
    collect(0, 20, to, cyc);
    tests++; if (to || beats.size() != 1 || beats[0] !== 33'd0) begin fails++; $display("FAIL clr_then_run: got %0d beats first %h expected 1 beat of 0", beats.size(), (beats.size() > 0) ? beats[0] : 33'h0); end
  endtask

  task automatic test_ignored();
    bit to; int cyc;
    spk(1, 4);
    send(OP_RUN, 16'd0);
    tests++; if (net_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL run0: got valid=%b busy=%b ready=%b expected 0/0/1", net_valid, busy, cmd_ready); end
    spk(5, 50);
    tests++; if (net_valid !== 1'b0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL spk_oob: got valid=%b ready=%b expected 0/1", net_valid, cmd_ready); end
    send(OP_RUN, 16'd1);
    collect(0, 20, to, cyc);
    tests++; if (to || beats.size() != 1 || beats[0] !== mk(0, 0, 4, 0, 0)) begin fails++; $display("FAIL ignored_buf: got %0d beats first %h expected %h", beats.size(), (beats.size() > 0) ? beats[0] : 33'h0, mk(0, 0, 4, 0, 0)); end
  endtask

  task automatic test_rst_mid_run();
    bit to; int cyc; int late;
    spk(2, 33);
    send(OP_RUN, 16'd10);
    tick();                               // beat 1 handshakes, beat 2 offered
    tests++; if (net_valid !== 1'b1 || cur_beat() !== 33'd0) begin fails++; $display("FAIL rst_beat2: got valid=%b beat=%h expected 1/0", net_valid, cur_beat()); end
    rst = 1'b1;                           // collides with beat-2 handshake
    tick();
    rst = 1'b0;
    tests++; if (net_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_abort: got valid=%b busy=%b ready=%b expected 0/0/1", net_valid, busy, cmd_ready); end
    late = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (net_valid) late++; end
    tests++; if (late != 0) begin fails++; $display("FAIL rst_no_beats: got %0d beats expected 0", late); end
    // Reset before the first handshake must discard the accumulated charge.
    spk(2, 33);
    net_ready = 1'b0;
    send(OP_RUN, 16'd10);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    net_ready = 1'b1;
    send(OP_RUN, 16'd1);
    collect(0, 20, to, cyc);
    tests++; if (to || beats.size() != 1 || beats[0] !== 33'd0) begin fails++; $display("FAIL rst_buf_zero: got %0d beats first %h expected 1 beat of 0", beats.size(), (beats.size() > 0) ? beats[0] : 33'h0); end
  endtask

  task automatic test_random();
    int mbuf[4];
    logic [32:0] exp_q[$];
    bit to; int cyc; int sel; int stall; int idx; int ch; int n; int bad;
    rst = 1'b1; tick(); rst = 1'b0;
    foreach (mbuf[i]) mbuf[i] = 0;
    for (int k = 0; k < 150; k++) begin
      sel = $urandom_range(0, 9);
      stall = $urandom_range(0, 3);
      exp_q.delete();
      tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rnd_ready[%0d]: got %b expected 1", k, cmd_ready); end
      if (sel < 5) begin
        idx = $urandom_range(0, 5);
        ch = $urandom_range(0, 255) - 128;
        if (idx < 4) begin
          mbuf[idx] = mbuf[idx] + ch;
          if (mbuf[idx] > 127) mbuf[idx] = 127;
          if (mbuf[idx] < -128) mbuf[idx] = -128;
        end
        spk(idx, ch);
      end else if (sel < 8) begin
        n = $urandom_range(0, 4);
        if (n > 0) begin
          exp_q.push_back(mk(0, mbuf[0], mbuf[1], mbuf[2], mbuf[3]));
          for (int j = 1; j < n; j++) exp_q.push_back(33'd0);
          foreach (mbuf[i]) mbuf[i] = 0;
        end
        send(OP_RUN, 16'(n));
      end else if (sel == 8) begin
        exp_q.push_back(mk(1, 0, 0, 0, 0));
        foreach (mbuf[i]) mbuf[i] = 0;
        send(OP_CLR, 16'(k));
      end else begin
        send(OP_NOP, 16'($urandom));
      end
      collect(stall, 40, to, cyc);
      bad = 0;
      if (beats.size() == exp_q.size())
        foreach (beats[i]) if (beats[i] !== exp_q[i]) bad++;
      tests++; if (to || beats.size() != exp_q.size() || bad != 0) begin fails++; $display("FAIL rnd_beats[%0d]: got %0d beats (%0d wrong) expected %0d", k, beats.size(), bad, exp_q.size()); end
      bad = 0;
      if (exp_q.size() > 0) foreach (held[i]) if (held[i] !== exp_q[0]) bad++;
      tests++; if (bad != 0) begin fails++; $display("FAIL rnd_hold[%0d]: got %0d altered held beats expected 0", k, bad); end
    end
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd = '0;
    net_ready = 1'b1;
    test_reset();
    test_spk_run();
    test_saturation();
    test_backpressure();
    test_clr();
    test_ignored();
    test_rst_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end
endmodule
